// File: rtl/turbo_check_decoder.sv
// turbo_check_decoder
//   Hard-decision check/correct stage for a rate-1/3 turbo-coded byte.
//   The codeword carries a systematic byte, an RSC parity over that byte and
//   an RSC parity over its bit-reversed interleave. Both parities are
//   recomputed serially, one bit per cycle, and compared with the received
//   ones. If both disagree, every single-bit flip of the systematic byte is
//   tried in turn. The first flip that makes both parities agree is taken as
//   the correction.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_data[23:0]         {parity2, parity1, systematic}
//   in_valid / in_ready   input handshake; a codeword is accepted only in IDLE
//   out_data[7:0]         decoded systematic byte
//   out_status[1:0]       0 clean, 1 parity-only error, 2 corrected,
//                         3 uncorrectable
//   out_valid / out_ready output handshake; the result is held until taken
//   word_cnt, err_cnt     saturating count of delivered words and of
//                         delivered words with non-zero status
module turbo_check_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [23:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic [1:0]       out_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, EVAL, OUT} state_t;

  state_t     state, state_nxt;
  logic [7:0] sys_r, rxp1_r, rxp2_r, mask_r, par1_r, par2_r;
  logic [2:0] bit_r, cand_r;
  logic       search_r;
  logic [1:0] st1_r, st2_r;

  logic [7:0] cand_w;
  logic [2:0] step1_w, step2_w;
  logic       m1_w, m2_w, both_ok_w;

  // Interleaver: bit i of the interleaved byte is systematic bit rev3(i).
  function automatic logic [2:0] rev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // One RSC step. Returns {parity bit, next s1, next s0} for state {s1, s0}.
  function automatic logic [2:0] rsc_step(input logic u, input logic [1:0] s);
    logic a;
    a = u ^ s[0] ^ s[1];
    return {a ^ s[1], s[0], a};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign cand_w    = sys_r ^ mask_r;
  assign step1_w   = rsc_step(cand_w[bit_r], st1_r);
  assign step2_w   = rsc_step(cand_w[rev3(bit_r)], st2_r);
  assign m1_w      = (par1_r != rxp1_r);
  assign m2_w      = (par2_r != rxp2_r);
  assign both_ok_w = !m1_w && !m2_w;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (bit_r == 3'd7) state_nxt = EVAL;
      EVAL: begin
        // First pass finishes unless both parities disagree; a search pass
        // finishes on a hit or after the last candidate bit.
        if (!search_r) state_nxt = (m1_w && m2_w) ? CALC : OUT;
        else           state_nxt = (both_ok_w || cand_r == 3'd7) ? OUT : CALC;
      end
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sys_r      <= '0;
      rxp1_r     <= '0;
      rxp2_r     <= '0;
      mask_r     <= '0;
      par1_r     <= '0;
      par2_r     <= '0;
      bit_r      <= '0;
      cand_r     <= '0;
      search_r   <= 1'b0;
      st1_r      <= '0;
      st2_r      <= '0;
      out_data   <= '0;
      out_status <= '0;
      word_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        // Accept: latch the codeword and start the first pass.
        IDLE: if (in_valid) begin
          sys_r    <= in_data[7:0];
          rxp1_r   <= in_data[15:8];
          rxp2_r   <= in_data[23:16];
          mask_r   <= '0;
          cand_r   <= '0;
          search_r <= 1'b0;
          bit_r    <= '0;
          st1_r    <= '0;
          st2_r    <= '0;
        end
        // Serial parity recompute; bit_r wraps back to 0 after bit 7.
        CALC: begin
          st1_r         <= step1_w[1:0];
          st2_r         <= step2_w[1:0];
          par1_r[bit_r] <= step1_w[2];
          par2_r[bit_r] <= step2_w[2];
          bit_r         <= bit_r + 3'd1;
        end
        // Compare and decide.
        EVAL: begin
          st1_r <= '0;
          st2_r <= '0;
          if (!search_r) begin
            if (m1_w && m2_w) begin
              search_r <= 1'b1;
              cand_r   <= '0;
              mask_r   <= 8'd1;
            end else begin
              out_data   <= sys_r;
              out_status <= both_ok_w ? 2'd0 : 2'd1;
            end
          end else if (both_ok_w) begin
            out_data   <= cand_w;
            out_status <= 2'd2;
          end else if (cand_r != 3'd7) begin
            cand_r <= cand_r + 3'd1;
            mask_r <= 8'd1 << (cand_r + 3'd1);
          end else begin
            out_data   <= sys_r;
            out_status <= 2'd3;
          end
        end
        // Deliver and count.
        OUT: if (out_ready) begin
          word_cnt <= sat_inc(word_cnt);
          if (out_status != 2'd0) err_cnt <= sat_inc(err_cnt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_check_decoder.sv
module tb_turbo_check_decoder;

  localparam int CW   = 4;
  localparam int SATV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [23:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic [1:0]    out_status;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_words = 0;
  int m_errs  = 0;

  turbo_check_decoder #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_status(out_status),
    .out_valid(out_valid), .out_ready(out_ready),
    .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] cw;
    logic [7:0]  ed;
    logic [1:0]  es;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference RSC parity, straight from the recursion a=u^s0^s1, p=a^s1.
  function automatic logic [7:0] rsc_par(input logic [7:0] u);
    int s1 = 0, s0 = 0, a;
    logic [7:0] p;
    for (int k = 0; k < 8; k++) begin
      a    = u[k] ^ s0 ^ s1;
      p[k] = a[0] ^ s1[0];
      s1   = s0;
      s0   = a;
    end
    return p;
  endfunction

  function automatic logic [7:0] ilv(input logic [7:0] u);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = u[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)];
    return r;
  endfunction

  // Latency = clock edges from the accept edge to the handshake edge with
  // out_ready held high.
  task automatic model(input logic [23:0] cw, output logic [7:0] d,
                       output logic [1:0] s, output int lat);
    logic [7:0] sys, c;
    logic ok1, ok2;
    sys = cw[7:0];
    ok1 = (rsc_par(sys) == cw[15:8]);
    ok2 = (rsc_par(ilv(sys)) == cw[23:16]);
    d = sys; lat = 10;
    if (ok1 && ok2)      s = 2'd0;
    else if (ok1 || ok2) s = 2'd1;
    else begin
      s = 2'd3; lat = 82;
      for (int j = 0; j < 8; j++) begin
        c = sys ^ (8'd1 << j);
        if (rsc_par(c) == cw[15:8] && rsc_par(ilv(c)) == cw[23:16]) begin
          d = c; s = 2'd2; lat = 10 + 9 * (j + 1);
          break;
        end
      end
    end
  endtask

  task automatic run_word(input logic [23:0] cw, input logic [7:0] ed,
                          input logic [1:0] es, input int el,
                          input int hold, input string tag);
    int k;
    logic [7:0] d0;
    logic [1:0] s0;
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    in_data   = cw;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    k = 0;
    // Keep in_valid high with junk data: it must be ignored while busy.
    while (!out_valid && k < 200) begin
      in_data = 24'($urandom);
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      chk({tag, ".timeout"}, 0, 1);
      return;
    end
    chk({tag, ".latency"}, k + 1, el);
    chk({tag, ".data"}, out_data, ed);
    chk({tag, ".status"}, out_status, es);
    chk({tag, ".in_ready_busy"}, in_ready, 0);
    d0 = out_data; s0 = out_status;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".stall_valid"}, out_valid, 1);
      chk({tag, ".stall_data"}, out_data, d0);
      chk({tag, ".stall_status"}, out_status, s0);
      chk({tag, ".stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    m_words = (m_words < SATV) ? m_words + 1 : SATV;
    if (es != 2'd0) m_errs = (m_errs < SATV) ? m_errs + 1 : SATV;
    chk({tag, ".valid_drop"}, out_valid, 0);
    chk({tag, ".in_ready_back"}, in_ready, 1);
    chk({tag, ".word_cnt"}, word_cnt, m_words);
    chk({tag, ".err_cnt"}, err_cnt, m_errs);
  endtask

  initial begin
    vec_t vecs[5];
    logic [7:0]  sys, p1, p2, ed;
    logic [1:0]  es;
    logic [23:0] cw;
    int el, seen;

    vecs[0] = '{24'h000000, 8'h00, 2'd0, 10};
    vecs[1] = '{24'hB7B701, 8'h01, 2'd0, 10};
    vecs[2] = '{24'hB7B601, 8'h01, 2'd1, 10};
    vecs[3] = '{24'hB7B700, 8'h01, 2'd2, 19};
    vecs[4] = '{24'h000003, 8'h03, 2'd3, 82};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.out_status", out_status, 0);
    chk("rst.word_cnt", word_cnt, 0);
    chk("rst.err_cnt", err_cnt, 0);

    for (int i = 0; i < 5; i++)
      run_word(vecs[i].cw, vecs[i].ed, vecs[i].es, vecs[i].lat, 0,
               $sformatf("vec%0d", i));

    // Uncorrectable word followed by a 20-cycle downstream stall.
    run_word(24'h000003, 8'h03, 2'd3, 82, 20, "stall");

    // Random words of several error types; counters saturate at 15 here.
    for (int r = 0; r < 40; r++) begin
      sys = 8'($urandom);
      p1  = rsc_par(sys);
      p2  = rsc_par(ilv(sys));
      case ($urandom_range(0, 3))
        0: cw = {p2, p1, sys};
        1: cw = {p2, p1, sys} ^ (24'd1 << (8 + $urandom_range(0, 15)));
        2: cw = {p2, p1, sys ^ (8'd1 << $urandom_range(0, 7))};
        default: cw = 24'($urandom);
      endcase
      model(cw, ed, es, el);
      run_word(cw, ed, es, el, ($urandom_range(0, 3) == 0) ? 3 : 0,
               $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a search abandons the word.
    in_data = 24'h000003; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_words = 0; m_errs = 0;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.word_cnt", word_cnt, 0);
    chk("midrst.err_cnt", err_cnt, 0);
    chk("midrst.out_data", out_data, 0);
    seen = 0;
    repeat (90) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("midrst.abandoned", seen, 0);
    run_word(24'hB7B701, 8'h01, 2'd0, 10, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
